dcache_wbuf: RTL
================

// Module: dcache_wbuf
// PURPOSE
//  Posted write buffer between the dcache write-back port and port 1 of sram_bus_interconnect.
//  - Absorbs dirty-line evictions so a refill read can start without waiting for memory writes.
//  - Issues buffered writes downstream in FIFO order.
//  - Holds back any read whose line address matches a buffered write.
//  - Provides the drain handshake used by fence_d.
// PARAMETERS
//  DEPTH     4    buffer entries; power of two, 2..8
//  LINE_LSB  5    low address bits ignored by the line compare (32-byte line)
// PORTS
//  clk          in   1    clock; all state updates on the rising edge
//  rst_n        in   1    asynchronous reset, active low
//  s_r_req      in   1    read request from dcache
//  s_r_type     in   6    read type (opaque, passed through)
//  s_r_addr     in   32   read address
//  s_r_rdy      out  1    read accepted when s_r_req && s_r_rdy
//  s_re_data    out  256  read data, passed through from m_re_data
//  s_re_valid   out  1    read data valid, passed through from m_re_valid
//  s_w_req      in   1    write request from dcache
//  s_w_type     in   6    write type (opaque)
//  s_w_addr     in   32   write address
//  s_w_data     in   256  write data
//  s_w_strb     in   16   write strobes
//  s_w_rdy      out  1    write accepted when s_w_req && s_w_rdy
//  m_r_req, m_r_type, m_r_addr   out 1/6/32   read request to interconnect
//  m_r_rdy      in   1    interconnect read accept
//  m_re_data    in   256  interconnect read data
//  m_re_valid   in   1    interconnect read data valid
//  m_w_req, m_w_type, m_w_addr, m_w_data, m_w_strb   out 1/6/32/256/16   write to interconnect
//  m_w_rdy      in   1    interconnect write accept
//  fence_req    in   1    level; asks for a full drain
//  fence_ok     out  1    one-cycle pulse when the drain completes
// BEHAVIOUR
//  - Reset (async, rst_n=0) clears: count, head and tail pointers, all entry valid bits, fence FSM=IDLE.
//    Outputs during and after reset: m_w_req=0, fence_ok=0, s_w_rdy=1, m_r_req=0 unless s_r_req is asserted.
//  - Reset asserted mid-drain discards all entries; no partial write is replayed.
//  - Push: s_w_rdy = (count!=DEPTH). It does not depend on a same-cycle pop, so a full buffer stalls a write even if a pop occurs.
//    An accepted write enters at tail; tail wraps DEPTH-1 -> 0.
//  - Pop: m_w_* are driven straight from the head entry registers. m_w_req = (count!=0).
//    Head advances on m_w_req && m_w_rdy and wraps DEPTH-1 -> 0.
//    An entry is visible on m_w_* one cycle after it is pushed (write latency 1 when the buffer is empty).
//  - Simultaneous push and pop: count is unchanged. Ordering is strict FIFO; entries are never merged.
//  - Read conflict:
//    conflict = s_r_req && (any valid entry, or an accepted push this cycle) with addr[31:LINE_LSB] == s_r_addr[31:LINE_LSB].
//    On conflict: m_r_req=0 and s_r_rdy=0.
//    Otherwise: m_r_req=s_r_req, s_r_rdy=m_r_rdy, and m_r_type/m_r_addr = s_r_* (combinational, 0-cycle).
//    The read proceeds in the cycle after the last matching entry pops.
//  - Response path: s_re_data and s_re_valid are wires from m_re_*; the block adds no latency and no buffering.
//  - Fence FSM:
//    IDLE -> DRAIN when fence_req=1.
//    DRAIN: s_w_rdy is forced to 0; go to DONE when count==0.
//    DONE: fence_ok=1 for exactly one cycle, then WAIT.
//    WAIT -> IDLE when fence_req=0.
//    A fence_req arriving with an empty buffer gives fence_ok 2 cycles later.
//  - Count width is $clog2(DEPTH)+1; it never exceeds DEPTH or goes below 0.
// STRUCTURE
//  - Bus widths (addr 32, data 256, type 6, strb 16) are shared `define constants in define.v, together with the fence state encoding.
//  - Sub-module wbuf_cam_fifo: storage, pointers, count, and the per-entry line-address compare.
//    Its outputs are hit, full, empty and the head entry.
//  - The top level holds the fence FSM and the handshake gating.
// TESTING
//  1. Reset, push addr 0x8000_0020 / data 0xA5..A5 / strb 0xFFFF, m_w_rdy=1 -> next cycle m_w_req=1 with the same fields; count back to 0 one cycle later.
//  2. m_w_rdy=0, push 4 writes (0x100, 0x200, 0x300, 0x400) -> s_w_rdy=0 after the 4th and a 5th write is stalled;
//     then m_w_rdy=1 -> pops in order 0x100..0x400 and the 5th write is accepted on the cycle after the first pop.
//  3. Entry 0x8000_0020 buffered, m_w_rdy=0, read 0x8000_0030 -> s_r_rdy=0, m_r_req=0;
//     set m_w_rdy=1 -> the read issues on m_r_* the cycle after the pop.
//  4. Entry 0x8000_0020 buffered, read 0x8000_1000 with m_r_rdy=1 -> accepted the same cycle; m_re_* echoed on s_re_* unchanged.
//  5. Two entries, fence_req=1, m_w_rdy=1 -> s_w_rdy=0 during the drain; fence_ok pulses once, 1 cycle after count reaches 0.
//  6. Three entries, assert rst_n=0 mid-drain -> m_w_req=0 immediately (async); after release count=0 and s_w_rdy=1.

Source files
------------

// File: rtl/dcache_wbuf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dcache_wbuf_pkg
// Description : Shared widths, buffer entry record, fence state encoding and
//               line-address compare helper for the dcache posted write buffer.
// Contents    : C_ADDR_W/C_DATA_W/C_TYPE_W/C_STRB_W bus widths,
//               wbuf_entry_t, fence_state_e, line_eq()
// Revision    : 1.0 - initial release
// ============================================================================
package dcache_wbuf_pkg;

    localparam int unsigned C_ADDR_W = 32;
    localparam int unsigned C_DATA_W = 256;
    localparam int unsigned C_TYPE_W = 6;
    localparam int unsigned C_STRB_W = 16;

    // One buffered write; exactly what is replayed on the downstream port.
    typedef struct packed {
        logic [C_TYPE_W-1:0] wtype;
        logic [C_ADDR_W-1:0] addr;
        logic [C_DATA_W-1:0] data;
        logic [C_STRB_W-1:0] strb;
    } wbuf_entry_t;

    typedef enum logic [1:0] {
        FENCE_IDLE  = 2'd0,
        FENCE_DRAIN = 2'd1,
        FENCE_DONE  = 2'd2,
        FENCE_WAIT  = 2'd3
    } fence_state_e;

    // Two addresses fall in the same cache line when they agree above lsb.
    function automatic logic line_eq(input logic [C_ADDR_W-1:0] a,
                                     input logic [C_ADDR_W-1:0] b,
                                     input int unsigned         lsb);
        return (a >> lsb) == (b >> lsb);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_wbuf_if.sv
`default_nettype none
// ============================================================================
// Module      : dcache_wbuf_if
// Description : Split read/write memory bus (read request, read response,
//               write request) used both between dcache and the write buffer
//               and between the write buffer and the interconnect.
// Modports    : master - issues r_req/w_req, receives rdy and read response
//               slave  - accepts requests, returns rdy and read response
// Revision    : 1.0 - initial release
// ============================================================================
interface dcache_wbuf_if;
    import dcache_wbuf_pkg::*;

    logic                r_req;
    logic [C_TYPE_W-1:0] r_type;
    logic [C_ADDR_W-1:0] r_addr;
    logic                r_rdy;
    logic [C_DATA_W-1:0] re_data;
    logic                re_valid;
    logic                w_req;
    logic [C_TYPE_W-1:0] w_type;
    logic [C_ADDR_W-1:0] w_addr;
    logic [C_DATA_W-1:0] w_data;
    logic [C_STRB_W-1:0] w_strb;
    logic                w_rdy;

    modport master (
        output r_req, r_type, r_addr,
        input  r_rdy, re_data, re_valid,
        output w_req, w_type, w_addr, w_data, w_strb,
        input  w_rdy
    );

    modport slave (
        input  r_req, r_type, r_addr,
        output r_rdy, re_data, re_valid,
        input  w_req, w_type, w_addr, w_data, w_strb,
        output w_rdy
    );

endinterface
`default_nettype wire

// File: rtl/dcache_wbuf_cam_fifo.sv
`default_nettype none
// ============================================================================
// Module      : dcache_wbuf_cam_fifo
// Description : FIFO storage for posted writes with a per-entry line-address
//               compare against an incoming read address.
// Ports       : clk, rst_n          clock, async active-low reset
//               push_i, push_entry_i write to tail (caller guarantees !full)
//               pop_i                retire head (caller guarantees !empty)
//               cmp_addr_i           address checked against buffered lines
//               hit_o                cmp_addr_i matches a valid entry or the
//                                    entry being pushed this cycle
//               full_o, empty_o      occupancy flags
//               head_o               oldest entry
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_wbuf_cam_fifo
    import dcache_wbuf_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned LINE_LSB = 5
) (
    input  wire logic                clk,
    input  wire logic                rst_n,
    input  wire logic                push_i,
    input  wire wbuf_entry_t         push_entry_i,
    input  wire logic                pop_i,
    input  wire logic [C_ADDR_W-1:0] cmp_addr_i,
    output logic                     hit_o,
    output logic                     full_o,
    output logic                     empty_o,
    output wbuf_entry_t              head_o
);

    localparam int unsigned          C_PTR_W    = $clog2(DEPTH);
    localparam int unsigned          C_CNT_W    = C_PTR_W + 1;
    localparam logic [C_PTR_W-1:0]   C_PTR_ONE  = C_PTR_W'(1);
    localparam logic [C_CNT_W-1:0]   C_CNT_ONE  = C_CNT_W'(1);
    localparam logic [C_CNT_W-1:0]   C_FULL_CNT = C_CNT_W'(DEPTH);

    wbuf_entry_t          mem_q [DEPTH];
    logic [DEPTH-1:0]     valid_q, valid_d;
    logic [C_PTR_W-1:0]   head_q, head_d;
    logic [C_PTR_W-1:0]   tail_q, tail_d;
    logic [C_CNT_W-1:0]   count_q, count_d;
    logic                 w_push;
    logic                 w_pop;
    logic [DEPTH-1:0]     w_match;

    assign full_o  = (count_q == C_FULL_CNT);
    assign empty_o = (count_q == '0);
    assign w_push  = push_i && !full_o;
    assign w_pop   = pop_i && !empty_o;
    assign head_o  = mem_q[head_q];

    // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        valid_d = valid_q;
        if (w_pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + C_PTR_ONE;
        end
        if (w_push) begin
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + C_PTR_ONE;
        end
        if (w_push && !w_pop) begin
            count_d = count_q + C_CNT_ONE;
        end else if (w_pop && !w_push) begin
            count_d = count_q - C_CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    // Payload needs no reset: valid_q/count_q gate every use of it.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[tail_q] <= push_entry_i;
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
        assign w_match[gi] = valid_q[gi] && line_eq(mem_q[gi].addr, cmp_addr_i, LINE_LSB);
    end

    // The entry being written this cycle is not yet in mem_q, so compare it
    // directly; otherwise a read could overtake a write to the same line.
    assign hit_o = (|w_match) || (w_push && line_eq(push_entry_i.addr, cmp_addr_i, LINE_LSB));

endmodule
`default_nettype wire

// File: rtl/dcache_wbuf.sv
`default_nettype none
// ============================================================================
// Module      : dcache_wbuf
// Description : Posted write buffer between the dcache write-back port and the
//               interconnect. Writes are queued and issued in FIFO order;
//               reads to a line that is still buffered are held back; a fence
//               request drains the buffer and answers with a one-cycle pulse.
// Ports       : clk, rst_n     clock, async active-low reset
//               s_bus          slave side, from dcache
//               m_bus          master side, to interconnect
//               fence_req_i    level request for a full drain
//               fence_ok_o     one-cycle pulse when the drain completes
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_wbuf
    import dcache_wbuf_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned LINE_LSB = 5
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    dcache_wbuf_if.slave  s_bus,
    dcache_wbuf_if.master m_bus,
    input  wire logic     fence_req_i,
    output logic          fence_ok_o
);

    fence_state_e state_q, state_d;
    wbuf_entry_t  w_push_entry;
    wbuf_entry_t  w_head;
    logic         w_full;
    logic         w_empty;
    logic         w_hit;
    logic         w_w_rdy;
    logic         w_push;
    logic         w_pop;
    logic         w_conflict;

    // Write accept looks only at registered state (no same-cycle pop credit).
    assign w_w_rdy = !w_full && (state_q != FENCE_DRAIN);
    assign w_push  = s_bus.w_req && w_w_rdy;
    assign w_pop   = !w_empty && m_bus.w_rdy;

    assign w_push_entry.wtype = s_bus.w_type;
    assign w_push_entry.addr  = s_bus.w_addr;
    assign w_push_entry.data  = s_bus.w_data;
    assign w_push_entry.strb  = s_bus.w_strb;

    dcache_wbuf_cam_fifo #(
        .DEPTH    (DEPTH),
        .LINE_LSB (LINE_LSB)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_i       (w_push),
        .push_entry_i (w_push_entry),
        .pop_i        (w_pop),
        .cmp_addr_i   (s_bus.r_addr),
        .hit_o        (w_hit),
        .full_o       (w_full),
        .empty_o      (w_empty),
        .head_o       (w_head)
    );

    assign s_bus.w_rdy  = w_w_rdy;

    assign m_bus.w_req  = !w_empty;
    assign m_bus.w_type = w_head.wtype;
    assign m_bus.w_addr = w_head.addr;
    assign m_bus.w_data = w_head.data;
    assign m_bus.w_strb = w_head.strb;

    // Reads pass straight through unless they target a buffered line.
    assign w_conflict   = s_bus.r_req && w_hit;
    assign m_bus.r_req  = s_bus.r_req && !w_hit;
    assign m_bus.r_type = s_bus.r_type;
    assign m_bus.r_addr = s_bus.r_addr;
    assign s_bus.r_rdy  = m_bus.r_rdy && !w_conflict;

    assign s_bus.re_data  = m_bus.re_data;
    assign s_bus.re_valid = m_bus.re_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FENCE_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // WAIT holds off a new drain until the requester drops fence_req_i,
    // so a held level produces only one fence_ok_o pulse.
    always_comb begin
        state_d    = state_q;
        fence_ok_o = 1'b0;
        case (state_q)
            FENCE_IDLE:  if (fence_req_i) state_d = FENCE_DRAIN;
            FENCE_DRAIN: if (w_empty)     state_d = FENCE_DONE;
            FENCE_DONE: begin
                fence_ok_o = 1'b1;
                state_d    = FENCE_WAIT;
            end
            FENCE_WAIT:  if (!fence_req_i) state_d = FENCE_IDLE;
            default:     state_d = FENCE_IDLE;
        endcase
    end

endmodule
`default_nettype wire
